// File: rtl/master_bridge_axi_w_drain_pkg.sv
// Shared master bridge definitions: W drain FSM states, DW width
// and the per-beat write-strobe selection.
package master_bridge_axi_w_drain_pkg;

    localparam int MB_DW = 32;
    localparam logic [3:0] STRB_ALL = 4'hF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } w_state_e;

    // Single-beat bursts use first_be; it also wins on beat 0.
    function automatic logic [3:0] beat_strb(
        input logic       len_zero,
        input logic       first,
        input logic       last,
        input logic [3:0] fbe,
        input logic [3:0] lbe
    );
        logic [3:0] s;
        s = STRB_ALL;
        if (len_zero || first) begin
            s = fbe;
        end else if (last) begin
            s = lbe;
        end
        return s;
    endfunction

endpackage

// File: rtl/master_bridge_w_out_reg.sv
// AXI W channel output register: load a new beat, hold while stalled,
// clear valid once a beat is taken with nothing to replace it.
module master_bridge_w_out_reg
    import master_bridge_axi_w_drain_pkg::*;
#(
    parameter int DATA_WIDTH = MB_DW
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [3:0]            i_strb,
    input  logic                  i_last,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [3:0]            o_strb,
    output logic                  o_last
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_strb  <= '0;
            o_last  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_strb  <= i_strb;
            o_last  <= i_last;
        end else if (i_clear) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/master_bridge_axi_w_drain.sv
// Drains one write burst per command from a FWFT data FIFO onto the
// AXI4 W channel, one beat per cycle, with first/last byte enables.
module master_bridge_axi_w_drain
    import master_bridge_axi_w_drain_pkg::*;
#(
    parameter int DATA_WIDTH = MB_DW,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    input  logic [3:0]            i_cmd_first_be,
    input  logic [3:0]            i_cmd_last_be,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_rd_inc,
    output logic                  o_wvalid,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [3:0]            o_wstrb,
    output logic                  o_wlast,
    input  logic                  i_wready,
    output logic                  o_busy
);

    localparam logic [LEN_WIDTH:0] CNT_ONE = 1;

    w_state_e             state_q;
    w_state_e             state_d;
    logic [LEN_WIDTH:0]   cnt_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [3:0]           fbe_q;
    logic [3:0]           lbe_q;
    logic                 done_q;

    logic       cmd_acc;
    logic       w_hs;
    logic       load;
    logic       beat_last;
    logic [3:0] strb_nxt;

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q == ST_BURST);
    assign cmd_acc     = i_cmd_valid && o_cmd_ready;
    assign w_hs        = o_wvalid && i_wready;

    // done_q stops further pops once the wlast beat sits in the register.
    assign load = (state_q == ST_BURST) && !i_fifo_empty
               && (!o_wvalid || i_wready) && !done_q;

    assign o_fifo_rd_inc = load;
    assign beat_last     = (cnt_q == {1'b0, len_q});
    assign strb_nxt      = beat_strb(len_q == '0, cnt_q == '0,
                                     beat_last, fbe_q, lbe_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_acc) state_d = ST_BURST;
            end
            ST_BURST: begin
                if (w_hs && o_wlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            fbe_q   <= '0;
            lbe_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_acc) begin
                len_q  <= i_cmd_len;
                fbe_q  <= i_cmd_first_be;
                lbe_q  <= i_cmd_last_be;
                cnt_q  <= '0;
                done_q <= 1'b0;
            end else if (load) begin
                cnt_q <= cnt_q + CNT_ONE;
                if (beat_last) done_q <= 1'b1;
            end
        end
    end

    master_bridge_w_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_w_out_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load),
        .i_clear (w_hs && !load),
        .i_data  (i_fifo_data),
        .i_strb  (strb_nxt),
        .i_last  (beat_last),
        .o_valid (o_wvalid),
        .o_data  (o_wdata),
        .o_strb  (o_wstrb),
        .o_last  (o_wlast)
    );

endmodule

// File: tb/tb_master_bridge_axi_w_drain.sv
// Bench for master_bridge_axi_w_drain: FIFO model, beat scoreboard,
// table of burst vectors plus reset and long-burst sequences.
module tb_master_bridge_axi_w_drain;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [7:0]  i_cmd_len;
    logic [3:0]  i_cmd_first_be;
    logic [3:0]  i_cmd_last_be;
    logic        i_fifo_empty;
    logic [31:0] i_fifo_data;
    logic        o_fifo_rd_inc;
    logic        o_wvalid;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_wlast;
    logic        i_wready;
    logic        o_busy;

    master_bridge_axi_w_drain #(
        .DATA_WIDTH (32),
        .LEN_WIDTH  (8)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_len      (i_cmd_len),
        .i_cmd_first_be (i_cmd_first_be),
        .i_cmd_last_be  (i_cmd_last_be),
        .i_fifo_empty   (i_fifo_empty),
        .i_fifo_data    (i_fifo_data),
        .o_fifo_rd_inc  (o_fifo_rd_inc),
        .o_wvalid       (o_wvalid),
        .o_wdata        (o_wdata),
        .o_wstrb        (o_wstrb),
        .o_wlast        (o_wlast),
        .i_wready       (i_wready),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          len;
        logic [3:0]  fbe;
        logic [3:0]  lbe;
        logic [31:0] base;
        int          n_pre;
        int          gap;
        int          sbeat;
        int          slen;
        bit          consec;
        int          exp_pops;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] fifo[$];
    logic [31:0] pend[$];
    beat_t       sb[$];

    bit          cmd_v;
    logic [7:0]  cmd_l;
    logic [3:0]  cmd_f;
    logic [3:0]  cmd_b;
    bit          accepted;
    bit          consec;
    int          cyc;
    int          acc_cyc;
    int          first_pop;
    int          last_hs_cyc;
    int          pops;
    int          hs;
    bit          gap_arm;
    int          gap_after;
    int          gap_n;
    int          gap_left;
    bit          stall_arm;
    int          stall_beat;
    int          stall_n;
    int          stall_left;
    logic [37:0] cap;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] strb_of(input int i, input int len,
                                           input logic [3:0] f,
                                           input logic [3:0] l);
        if (len == 0 || i == 0) return f;
        if (i == len) return l;
        return 4'hF;
    endfunction

    task automatic cycle();
        beat_t e;
        @(negedge i_clk);
        i_cmd_valid    = cmd_v;
        i_cmd_len      = cmd_l;
        i_cmd_first_be = cmd_f;
        i_cmd_last_be  = cmd_b;
        if (gap_arm && fifo.size() == 0 && pops == gap_after) begin
            gap_left = gap_n;
            gap_arm  = 1'b0;
        end
        if (stall_arm && hs == stall_beat && o_wvalid) begin
            stall_left = stall_n;
            stall_arm  = 1'b0;
            cap = {o_wvalid, o_wdata, o_wstrb, o_wlast};
        end
        i_wready     = (stall_left == 0);
        i_fifo_empty = (fifo.size() == 0);
        i_fifo_data  = i_fifo_empty ? 32'h0 : fifo[0];
        #1;
        if (cmd_v && o_cmd_ready) begin
            accepted = 1'b1;
            acc_cyc  = cyc;
        end
        if (i_fifo_empty) chk("no_pop_when_empty", o_fifo_rd_inc, 0);
        if (stall_left > 0) begin
            chk("stall_stable", {o_wvalid, o_wdata, o_wstrb, o_wlast}, cap);
            chk("stall_no_pop", o_fifo_rd_inc, 0);
            stall_left--;
        end
        if (o_fifo_rd_inc) begin
            if (first_pop < 0) first_pop = cyc;
            if (fifo.size() > 0) void'(fifo.pop_front());
            pops++;
        end
        if (gap_left > 0) begin
            gap_left--;
            if (gap_left == 0) begin
                chk("gap_wvalid_low", o_wvalid, 0);
                while (pend.size() > 0) fifo.push_back(pend.pop_front());
                fifo.push_back(SENTINEL);
            end
        end
        if (o_wvalid && i_wready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("wdata", o_wdata, e.data);
                chk("wstrb", o_wstrb, e.strb);
                chk("wlast", o_wlast, e.last);
            end
            if (o_wlast) chk("no_ready_on_last_hs", o_cmd_ready, 0);
            if (consec && hs > 0) chk("beat_per_cycle", cyc - last_hs_cyc, 1);
            last_hs_cyc = cyc;
            hs++;
        end
        cyc++;
    endtask

    task automatic start_cmd(input vec_t v);
        logic [31:0] w;
        fifo.delete();
        pend.delete();
        sb.delete();
        for (int i = 0; i <= v.len; i++) begin
            w = v.base ^ (i * 32'h9E37_79B9);
            sb.push_back('{w, strb_of(i, v.len, v.fbe, v.lbe), i == v.len});
            if (i < v.n_pre) fifo.push_back(w);
            else pend.push_back(w);
        end
        if (pend.size() == 0) fifo.push_back(SENTINEL);
        pops = 0;
        hs = 0;
        first_pop = -1;
        consec = v.consec;
        gap_arm = (v.gap > 0);
        gap_after = v.n_pre;
        gap_n = v.gap;
        gap_left = 0;
        stall_arm = (v.slen > 0);
        stall_beat = v.sbeat;
        stall_n = v.slen;
        stall_left = 0;
        accepted = 1'b0;
        cmd_v = 1'b1;
        cmd_l = v.len[7:0];
        cmd_f = v.fbe;
        cmd_b = v.lbe;
        for (int g = 0; g < 10 && !accepted; g++) cycle();
        cmd_v = 1'b0;
        chk("cmd_accepted", accepted, 1);
    endtask

    task automatic run_cmd(input vec_t v);
        int guard;
        start_cmd(v);
        cycle();
        chk("busy_in_burst", o_busy, 1);
        guard = 0;
        while (hs < v.len + 1 && guard < 3000) begin
            cycle();
            guard++;
        end
        chk("burst_done_in_time", guard < 3000, 1);
        if (v.n_pre > 0) chk("first_pop_latency", first_pop - acc_cyc, 1);
        cycle();
        chk("busy_after", o_busy, 0);
        chk("cmd_ready_after", o_cmd_ready, 1);
        chk("pop_count", pops, v.exp_pops);
        chk("sb_drained", sb.size(), 0);
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
        vecs[0] = '{0, 4'b0110, 4'b1111, 32'hA5A5_A5A5, 1, 0, 0, 0, 1, 1};
        vecs[1] = '{3, 4'b1100, 4'b0011, 32'h1234_5678, 4, 0, 0, 0, 1, 4};
        vecs[2] = '{3, 4'b1010, 4'b0101, 32'h0BAD_F00D, 4, 0, 1, 5, 0, 4};
        vecs[3] = '{7, 4'b0001, 4'b1000, 32'hC0FF_EE00, 3, 4, 0, 0, 0, 8};
        vecs[4] = '{1, 4'b0111, 4'b1110, 32'h5555_AAAA, 2, 0, 0, 0, 1, 2};
        vecs[5] = '{2, 4'b1001, 4'b0110, 32'h7777_1111, 3, 0, 2, 3, 0, 3};

        cyc = 0;
        cmd_v = 0;
        cmd_l = '0;
        cmd_f = '0;
        cmd_b = '0;
        stall_left = 0;
        gap_left = 0;
        stall_arm = 0;
        gap_arm = 0;
        i_rst = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_len = '0;
        i_cmd_first_be = '0;
        i_cmd_last_be = '0;
        i_fifo_empty = 1'b0;
        i_fifo_data = 32'h1111_1111;
        i_wready = 1'b1;
        #1;
        chk("rst_wvalid", o_wvalid, 0);
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_no_pop", o_fifo_rd_inc, 0);
        chk("rst_wout", {o_wdata, o_wstrb, o_wlast}, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int k = 0; k < 6; k++) run_cmd(vecs[k]);

        // Reset in the middle of a len=3 burst, after beat 1 is taken.
        v = '{3, 4'b1111, 4'b1111, 32'h3C3C_0000, 4, 0, 0, 0, 0, 4};
        start_cmd(v);
        for (int g = 0; g < 20 && hs < 2; g++) cycle();
        chk("pre_rst_beats", hs, 2);
        @(negedge i_clk);
        i_fifo_empty = (fifo.size() == 0);
        i_rst = 1'b1;
        #1;
        chk("midrst_wvalid", o_wvalid, 0);
        chk("midrst_wout", {o_wdata, o_wstrb, o_wlast}, 0);
        chk("midrst_cmd_ready", o_cmd_ready, 1);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_no_pop", o_fifo_rd_inc, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("postrst_no_pop", o_fifo_rd_inc, 0);
        chk("postrst_wvalid", o_wvalid, 0);
        v = '{0, 4'b0011, 4'b1100, 32'h0F0F_0F0F, 1, 0, 0, 0, 1, 1};
        run_cmd(v);

        v = '{255, 4'b1110, 4'b0111, 32'h8000_0001, 256, 0, 0, 0, 1, 256};
        run_cmd(v);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/master_bridge_axi_w_drain.md
MASTER_BRIDGE_AXI_W_DRAIN -- requirements
Module: master_bridge_axi_w_drain

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: FIFO word and AXI WDATA width, one DW per beat.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 8: burst length field width, AXI AWLEN encoding (beats-1).
REQ-003 The block SHALL have port i_clk  input  1  single clock: the FIFO read clock and the AXI clock.
REQ-004 The block SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_cmd_valid  input  1  write-burst command valid.
REQ-006 The block SHALL have port o_cmd_ready  output  1  command accepted when high together with i_cmd_valid.
REQ-007 The block SHALL have port i_cmd_len  input  LEN_WIDTH  number of beats minus 1.
REQ-008 The block SHALL have port i_cmd_first_be  input  4  byte enables of the first DW.
REQ-009 The block SHALL have port i_cmd_last_be  input  4  byte enables of the last DW.
REQ-010 The block SHALL have port i_fifo_empty  input  1  data FIFO empty flag, read side.
REQ-011 The block SHALL have port i_fifo_data  input  DATA_WIDTH  FIFO head word, first-word-fall-through.
REQ-012 The block SHALL have port o_fifo_rd_inc  output  1  pop strobe, one word per cycle high.
REQ-013 The block SHALL have ports o_wvalid (output, 1), o_wdata (output, DATA_WIDTH), o_wstrb (output, 4), o_wlast (output, 1) and i_wready (input, 1), forming the AXI4 W channel.
REQ-014 The block SHALL have port o_busy  output  1  high while a burst is in progress.

Function
REQ-015 The block SHALL implement an FSM with two states. IDLE goes to BURST on i_cmd_valid&&o_cmd_ready. BURST goes to IDLE in the cycle the beat with o_wlast is accepted (o_wvalid&&i_wready&&o_wlast).
REQ-016 o_cmd_ready SHALL equal (state==IDLE). In the accepting cycle the block SHALL latch len, first_be and last_be, and clear the beat counter to 0.
REQ-017 The W outputs SHALL be registered. A load SHALL occur when state==BURST, !i_fifo_empty, (!o_wvalid||i_wready), and no beat has yet been loaded with o_wlast set.
REQ-018 On a load, o_fifo_rd_inc SHALL be high in the same cycle (combinational). o_wdata SHALL take i_fifo_data, o_wvalid SHALL be set, and the beat counter SHALL increment.
REQ-019 o_wlast SHALL be set on the load whose counter value equals the latched len.
REQ-020 o_wstrb SHALL be set on each load as follows: first_be if len==0; otherwise first_be on beat 0, last_be on beat len, and 4'hF on middle beats.
REQ-021 If (o_wvalid&&i_wready) occurs without a load, o_wvalid SHALL clear. o_wvalid, o_wdata, o_wstrb and o_wlast SHALL hold stable while o_wvalid&&!i_wready (AXI rule).
REQ-022 Throughput SHALL be one beat per cycle under continuous !i_fifo_empty and i_wready. Latency from the FIFO word to o_wvalid SHALL be 1 cycle.
REQ-023 When the FIFO is empty mid-burst, the block SHALL NOT load or pop. o_wvalid SHALL drop after the pending beat is accepted, and the burst SHALL resume when data arrives.
REQ-024 o_fifo_rd_inc SHALL never assert while i_fifo_empty is high or in IDLE. The total number of pops per burst SHALL be exactly len+1.
REQ-025 The beat counter SHALL be LEN_WIDTH+1 bits wide. len=255 gives 256 beats with no wrap-around.
REQ-026 A new command SHALL NOT be accepted in the cycle the last beat handshakes. The earliest next acceptance is the following cycle.
REQ-027 o_busy SHALL equal (state==BURST).

Reset
REQ-028 On i_rst, asynchronously: state SHALL go to IDLE, counter to 0, o_wvalid to 0, o_wlast to 0, o_wdata to 0, o_wstrb to 0, o_busy to 0, and o_cmd_ready SHALL be 1 after reset.
REQ-029 Reset mid-burst SHALL abandon the burst without further pops. FIFO contents SHALL NOT be flushed by this block.

Structure
REQ-030 The FSM state encodings and the DW-width constant (32) SHALL be placed in the shared master bridge package/defines file.
REQ-031 The block SHALL contain one sub-module, master_bridge_w_out_reg: the W channel output register with load/hold/clear control.

Verification
REQ-032 Scenario: len=0, first_be=4'b0110, FIFO holds 0xA5A5A5A5, wready=1 -> one beat, wdata=0xA5A5A5A5, wstrb=0110, wlast=1, exactly 1 pop, back to IDLE.
REQ-033 Scenario: len=3, first_be=1100, last_be=0011, 4 words queued, wready=1 -> beats on 4 consecutive cycles with wstrb 1100,1111,1111,0011, wlast only on beat 3.
REQ-034 Scenario: len=3, wready held low 5 cycles on beat 1 -> outputs stable, no pop during the stall, 4 pops total.
REQ-035 Scenario: len=7, FIFO empty after word 2 for 4 cycles -> o_wvalid drops after beat 2, resumes, 8 beats in order, no pop while empty.
REQ-036 Scenario: i_rst pulsed after beat 1 of len=3 -> all outputs 0 immediately, o_cmd_ready=1; a new len=0 command then completes normally.
REQ-037 Scenario: len=255 -> 256 beats, wlast on beat 255 only, counter does not wrap early.
